image_window_compositor: RTL and testbench

- Successor to the fixed two-image address generator in the graphics path.
- Sits between the VGA timing generator and the framebuffer memory.
- Supports NUM_IMAGES independently placed, sized, scaled and enabled windows on screen.
- For each visible pixel it emits the framebuffer address and the winning window index; window geometry is written through a config port and double-buffered so changes apply only at frame boundaries.

---
 rtl/image_window_compositor_if.sv | 31 +++
 rtl/image_window_compositor.sv | 199 +++++++++++++++++++
 tb/tb_image_window_compositor.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_window_compositor_if.sv
// Bundles the timing inputs, the window config port and the pixel outputs
// of the window compositor into one interface.
// master: timing/config source and pixel consumer; slave: the compositor.
interface image_window_compositor_if #(
    parameter int NUM_IMAGES = 2,
    parameter int ADDR_W     = 19
);
    localparam int IDX_W = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
    localparam int SEL_W = $clog2(NUM_IMAGES + 1);

    logic              hsync;
    logic              vsync;
    logic              visible;
    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [2:0]        cfg_field;
    logic [ADDR_W-1:0] cfg_data;
    logic [SEL_W-1:0]  color_selector;
    logic [ADDR_W-1:0] address;
    logic              pix_valid;

    modport master (
        output hsync, vsync, visible, cfg_we, cfg_idx, cfg_field, cfg_data,
        input  color_selector, address, pix_valid
    );

    modport slave (
        input  hsync, vsync, visible, cfg_we, cfg_idx, cfg_field, cfg_data,
        output color_selector, address, pix_valid
    );
endinterface

// File: rtl/image_window_compositor.sv
// Maps each visible pixel to a framebuffer address and winning window index.
// Latency: 2 cycles from visible/coordinate to address/color_selector/pix_valid.
// No backpressure: free-running pixel stream, one pixel per clk.
//
// Ports: clk, reset (async active-low), bus (slave modport): hsync/vsync/visible
// timing in, cfg_we/cfg_idx/cfg_field/cfg_data window config in,
// color_selector/address/pix_valid out.
module image_window_compositor #(
    parameter int NUM_IMAGES = 2,
    parameter int ADDR_W     = 19,
    parameter int H_W        = 11,
    parameter int V_W        = 10,
    parameter int DEF_W      = 480,
    parameter int DEF_H      = 320
) (
    input  logic                      clk,
    input  logic                      reset,
    image_window_compositor_if.slave  bus
);
    localparam int IDX_W  = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
    localparam int SEL_W  = $clog2(NUM_IMAGES + 1);
    localparam int PROD_W = H_W + V_W;
    localparam logic [SEL_W-1:0] BG_SEL = SEL_W'(NUM_IMAGES);

    // ---------------- pixel counters ----------------
    logic [H_W-1:0] h_count;
    logic [V_W-1:0] v_count;
    logic           visible_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_count   <= '0;
            v_count   <= '0;
            visible_q <= 1'b0;
        end else begin
            visible_q <= bus.visible;
            if (!bus.vsync) begin
                h_count <= '0;
                v_count <= '0;
            end else if (bus.visible) begin
                if (h_count != '1) h_count <= h_count + 1'b1;
            end else if (visible_q) begin
                // end of the visible part of a line
                h_count <= '0;
                if (v_count != '1) v_count <= v_count + 1'b1;
            end
        end
    end

    // ---------------- window config: shadow + active ----------------
    logic [H_W-1:0]    sh_x     [NUM_IMAGES];
    logic [V_W-1:0]    sh_y     [NUM_IMAGES];
    logic [H_W-1:0]    sh_w     [NUM_IMAGES];
    logic [V_W-1:0]    sh_h     [NUM_IMAGES];
    logic [ADDR_W-1:0] sh_base  [NUM_IMAGES];
    logic [1:0]        sh_scale [NUM_IMAGES];
    logic              sh_en    [NUM_IMAGES];

    logic [H_W-1:0]    act_x     [NUM_IMAGES];
    logic [V_W-1:0]    act_y     [NUM_IMAGES];
    logic [H_W-1:0]    act_w     [NUM_IMAGES];
    logic [V_W-1:0]    act_h     [NUM_IMAGES];
    logic [ADDR_W-1:0] act_base  [NUM_IMAGES];
    logic [1:0]        act_scale [NUM_IMAGES];
    logic              act_en    [NUM_IMAGES];

    // Out-of-range cfg_idx matches no window, so the write is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IMAGES; i++) begin
                sh_x[i]     <= '0;
                sh_y[i]     <= '0;
                sh_w[i]     <= H_W'(DEF_W);
                sh_h[i]     <= V_W'(DEF_H);
                sh_base[i]  <= '0;
                sh_scale[i] <= '0;
                sh_en[i]    <= (i == 0);
            end
        end else if (bus.cfg_we) begin
            for (int i = 0; i < NUM_IMAGES; i++) begin
                if (bus.cfg_idx == IDX_W'(i)) begin
                    case (bus.cfg_field)
                        3'd0: sh_x[i]    <= H_W'(bus.cfg_data);
                        3'd1: sh_y[i]    <= V_W'(bus.cfg_data);
                        3'd2: sh_w[i]    <= H_W'(bus.cfg_data);
                        3'd3: sh_h[i]    <= V_W'(bus.cfg_data);
                        3'd4: sh_base[i] <= bus.cfg_data;
                        3'd5: sh_scale[i] <= (bus.cfg_data[1:0] == 2'd3) ? 2'd2
                                                                         : bus.cfg_data[1:0];
                        3'd6: sh_en[i]   <= bus.cfg_data[0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Commit happens on every vsync-low cycle; a write landing in the same
    // cycle only reaches the shadow and is picked up by the next commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_IMAGES; i++) begin
                act_x[i]     <= '0;
                act_y[i]     <= '0;
                act_w[i]     <= H_W'(DEF_W);
                act_h[i]     <= V_W'(DEF_H);
                act_base[i]  <= '0;
                act_scale[i] <= '0;
                act_en[i]    <= (i == 0);
            end
        end else if (!bus.vsync) begin
            for (int i = 0; i < NUM_IMAGES; i++) begin
                act_x[i]     <= sh_x[i];
                act_y[i]     <= sh_y[i];
                act_w[i]     <= sh_w[i];
                act_h[i]     <= sh_h[i];
                act_base[i]  <= sh_base[i];
                act_scale[i] <= sh_scale[i];
                act_en[i]    <= sh_en[i];
            end
        end
    end

    // ---------------- stage 1: per-window hit test ----------------
    logic           hit1 [NUM_IMAGES];
    logic [H_W-1:0] rx1  [NUM_IMAGES];
    logic [V_W-1:0] ry1  [NUM_IMAGES];
    logic           vis1;

    // One extra bit on each side so x+w / y+h cannot wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vis1 <= 1'b0;
            for (int i = 0; i < NUM_IMAGES; i++) begin
                hit1[i] <= 1'b0;
                rx1[i]  <= '0;
                ry1[i]  <= '0;
            end
        end else begin
            vis1 <= bus.visible;
            for (int i = 0; i < NUM_IMAGES; i++) begin
                hit1[i] <= act_en[i] && bus.visible
                        && ({1'b0, h_count} >= {1'b0, act_x[i]})
                        && ({1'b0, h_count} <  ({1'b0, act_x[i]} + {1'b0, act_w[i]}))
                        && ({1'b0, v_count} >= {1'b0, act_y[i]})
                        && ({1'b0, v_count} <  ({1'b0, act_y[i]} + {1'b0, act_h[i]}));
                rx1[i]  <= h_count - act_x[i];
                ry1[i]  <= v_count - act_y[i];
            end
        end
    end

    // ---------------- stage 2: priority select + address ----------------
    // Width/base/scale are read from the active set here; it only changes
    // while vsync is low, when no pixels are in flight.
    logic [PROD_W-1:0] line_off [NUM_IMAGES];
    logic [ADDR_W-1:0] win_addr [NUM_IMAGES];
    logic [SEL_W-1:0]  sel_n;
    logic [ADDR_W-1:0] addr_n;

    always_comb begin
        for (int i = 0; i < NUM_IMAGES; i++) begin
            line_off[i] = PROD_W'(act_w[i] >> act_scale[i])
                        * PROD_W'(ry1[i] >> act_scale[i]);
            win_addr[i] = act_base[i] + ADDR_W'(rx1[i] >> act_scale[i])
                        + ADDR_W'(line_off[i]);
        end
    end

    // Walk downwards so the lowest-index hit is the last one assigned.
    always_comb begin
        sel_n  = BG_SEL;
        addr_n = '0;
        for (int i = NUM_IMAGES - 1; i >= 0; i--) begin
            if (hit1[i]) begin
                sel_n  = SEL_W'(i);
                addr_n = win_addr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.color_selector <= BG_SEL;
            bus.address        <= '0;
            bus.pix_valid      <= 1'b0;
        end else begin
            bus.color_selector <= sel_n;
            bus.address        <= addr_n;
            bus.pix_valid      <= vis1;
        end
    end

    // hsync carries no information for the counters; upper cfg_data bits
    // are ignored by the narrower fields.
    logic unused_inputs;
    assign unused_inputs = ^{bus.hsync, bus.cfg_data};

endmodule

// File: tb/tb_image_window_compositor.sv
// Directed test of image_window_compositor: drives synthetic frames
// (short lines where only the target line is long) and checks hand-computed
// address/selector values two cycles after each chosen pixel.
module tb_image_window_compositor;
    localparam int N  = 2;
    localparam int AW = 19;
    localparam int BG = N;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    image_window_compositor_if #(.NUM_IMAGES(N), .ADDR_W(AW)) bus();

    image_window_compositor #(
        .NUM_IMAGES(N), .ADDR_W(AW), .H_W(11), .V_W(10),
        .DEF_W(480), .DEF_H(320)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int fails   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int    h;
        int    v;
        int    sel;
        int    addr;
        string tag;
    } exp_t;

    exp_t exp_q[$];

    // pixel history: index 1 is what the outputs reflect at a negedge
    logic hist_vis [2];
    int   hist_h   [2];
    int   hist_v   [2];
    logic lag_chk  = 1'b0;
    logic nxt_we   = 1'b0;
    logic nxt_hs   = 1'b1;
    int   nxt_idx  = 0;
    int   nxt_fld  = 0;
    int   nxt_dat  = 0;

    task automatic expect_pix(input string tag, input int h, input int v, input int sel, input int addr);
        exp_t e;
        e.h = h; e.v = v; e.sel = sel; e.addr = addr; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic clear_hist();
        for (int i = 0; i < 2; i++) begin
            hist_vis[i] = 1'b0;
            hist_h[i]   = -1;
            hist_v[i]   = -1;
        end
    endtask

    // One clock: check outputs for the pixel driven two steps ago, then drive.
    task automatic step(input logic vis, input logic vs, input int ph, input int pv);
        @(negedge clk);
        if (lag_chk) check("lag_pix_valid", {31'b0, bus.pix_valid}, {31'b0, hist_vis[1]});
        if (hist_vis[1]) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].h == hist_h[1] && exp_q[i].v == hist_v[1]) begin
                    check({exp_q[i].tag, "_sel"},   32'(bus.color_selector), exp_q[i].sel);
                    check({exp_q[i].tag, "_addr"},  32'(bus.address),        exp_q[i].addr);
                    check({exp_q[i].tag, "_valid"}, {31'b0, bus.pix_valid},  1);
                    exp_q.delete(i);
                    break;
                end
            end
        end
        hist_vis[1] = hist_vis[0]; hist_h[1] = hist_h[0]; hist_v[1] = hist_v[0];
        hist_vis[0] = vis;         hist_h[0] = ph;        hist_v[0] = pv;
        bus.visible   = vis;
        bus.vsync     = vs;
        bus.hsync     = nxt_hs;
        bus.cfg_we    = nxt_we;
        bus.cfg_idx   = nxt_idx[0:0];
        bus.cfg_field = nxt_fld[2:0];
        bus.cfg_data  = nxt_dat[AW-1:0];
        nxt_we = 1'b0;
        nxt_hs = 1'b1;
    endtask

    task automatic cfg(input int idx, input int fld, input int dat, input logic vs = 1'b1);
        nxt_we  = 1'b1;
        nxt_idx = idx;
        nxt_fld = fld;
        nxt_dat = dat;
        step(1'b0, vs, 0, 0);
    endtask

    task automatic run_line(input int pv, input int nvis);
        for (int i = 0; i < nvis; i++) step(1'b1, 1'b1, i, pv);
        nxt_hs = 1'b0;
        step(1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b1, 0, 0);
    endtask

    // vsync-low pulse (commit) then 'upto' one-pixel lines to reach line 'upto'
    task automatic frame_lines(input int upto);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 0, 0);
        for (int l = 0; l < upto; l++) run_line(l, 1);
    endtask

    task automatic frame_done();
        while (exp_q.size() > 0) begin
            check({exp_q[0].tag, "_seen"}, 0, 1);
            exp_q.delete(0);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hsync = 1'b1; bus.vsync = 1'b1; bus.visible = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_field = '0; bus.cfg_data = '0;
        clear_hist();
        repeat (3) @(negedge clk);
        check("rst_sel",   32'(bus.color_selector), BG);
        check("rst_addr",  32'(bus.address),        0);
        check("rst_valid", {31'b0, bus.pix_valid},  0);
        reset = 1'b1;

        // defaults: window 0 = 480x320 at origin
        frame_lines(0);
        lag_chk = 1'b1;
        expect_pix("def_origin", 0, 0, 0, 0);
        expect_pix("def_last_in_line0", 479, 0, 0, 479);
        expect_pix("def_right_of_win", 480, 0, BG, 0);
        run_line(0, 481);
        lag_chk = 1'b0;
        for (int l = 1; l < 319; l++) run_line(l, 1);
        expect_pix("def_bottom_right", 479, 319, 0, 153599);
        run_line(319, 480);
        expect_pix("def_below_win", 0, 320, BG, 0);
        run_line(320, 1);
        frame_done();

        // window 1 overlapping window 0
        cfg(1, 0, 100); cfg(1, 1, 50); cfg(1, 2, 200);
        cfg(1, 3, 100); cfg(1, 4, 200000); cfg(1, 6, 1);
        frame_lines(60);
        expect_pix("ovl_win0_wins", 150, 60, 0, 28950);
        run_line(60, 151);
        frame_done();

        cfg(0, 6, 0);
        frame_lines(60);
        expect_pix("ovl_left_edge_out", 99, 60, BG, 0);
        expect_pix("ovl_left_edge_in", 100, 60, 1, 202000);
        expect_pix("ovl_win1", 150, 60, 1, 202050);
        expect_pix("ovl_right_edge_in", 299, 60, 1, 202199);
        expect_pix("ovl_right_edge_out", 300, 60, BG, 0);
        run_line(60, 301);
        for (int l = 61; l < 149; l++) run_line(l, 1);
        expect_pix("ovl_bottom_in", 100, 149, 1, 219800);
        run_line(149, 101);
        expect_pix("ovl_bottom_out", 100, 150, BG, 0);
        run_line(150, 101);
        frame_done();

        // scaling
        cfg(0, 6, 1); cfg(0, 5, 1);
        frame_lines(4);
        expect_pix("scale1_2_4", 2, 4, 0, 481);
        run_line(4, 3);
        expect_pix("scale1_3_5", 3, 5, 0, 481);
        run_line(5, 4);
        frame_done();
        cfg(0, 5, 3);                      // stored as 2
        frame_lines(9);
        expect_pix("scale3_capped", 7, 9, 0, 241);
        run_line(9, 8);
        frame_done();
        cfg(0, 5, 0);

        // double buffering
        frame_lines(2);
        cfg(0, 0, 10);                     // mid-frame, vsync high
        expect_pix("dbuf_old_x", 5, 2, 0, 965);
        expect_pix("dbuf_old_x10", 10, 2, 0, 970);
        run_line(2, 11);
        frame_done();
        frame_lines(2);
        expect_pix("dbuf_new_x_miss", 5, 2, BG, 0);
        expect_pix("dbuf_new_x_edge", 10, 2, 0, 960);
        run_line(2, 11);
        frame_done();
        cfg(0, 0, 0, 1'b0);                // write during a one-cycle commit
        step(1'b0, 1'b1, 0, 0);
        run_line(0, 1); run_line(1, 1);
        expect_pix("commit_same_cycle", 5, 2, BG, 0);
        run_line(2, 6);
        frame_done();
        frame_lines(2);
        expect_pix("commit_next_pulse", 5, 2, 0, 965);
        run_line(2, 6);
        frame_done();

        // boundaries
        cfg(0, 7, 0);
        frame_lines(0);
        expect_pix("field7_ignored", 0, 0, 0, 0);
        run_line(0, 1);
        frame_done();
        cfg(0, 2, 0);
        frame_lines(0);
        expect_pix("zero_width", 0, 0, BG, 0);
        run_line(0, 1);
        frame_done();
        cfg(0, 2, 480); cfg(0, 4, 524000);
        frame_lines(0);
        expect_pix("base_wrap", 479, 0, 0, 191);
        run_line(0, 480);
        frame_done();

        // async reset mid-line; shadow x=10 is pending and must be lost
        frame_lines(0);
        cfg(0, 0, 10);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, i, 0);
        check("prerst_valid", {31'b0, bus.pix_valid}, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_sel",   32'(bus.color_selector), BG);
        check("midrst_addr",  32'(bus.address),        0);
        check("midrst_valid", {31'b0, bus.pix_valid},  0);
        @(negedge clk);
        bus.visible = 1'b0;
        reset = 1'b1;
        clear_hist();
        expect_pix("postrst_first", 0, 0, 0, 0);
        expect_pix("postrst_x5", 5, 0, 0, 5);
        expect_pix("postrst_x479", 479, 0, 0, 479);
        run_line(0, 480);
        frame_done();
        frame_lines(0);
        expect_pix("postrst_shadow_default", 5, 0, 0, 5);
        run_line(0, 6);
        frame_done();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
